// File: rtl/chip8_fetch_decode.sv
// rtl/chip8_fetch_decode.sv - CHIP-8 two-byte instruction fetch and registered decode with valid/ready output
module chip8_fetch_decode #(
    parameter int                ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] PC_RESET    = ADDR_W'('h200),
    parameter int                MEM_LATENCY = 1,
    parameter bit                SCHIP       = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_addr,
    input  logic              pc_skip,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [15:0]       opcode,
    output logic [3:0]        op_main,
    output logic [3:0]        x,
    output logic [3:0]        y,
    output logic [3:0]        n,
    output logic [7:0]        nn,
    output logic [11:0]       nnn,
    output logic [4:0]        op_sub,
    output logic [2:0]        alu_op,
    output logic              alu_switchxy,
    output logic              illegal
);

    localparam logic [2:0] ALU_ASSIGN = 3'd0;
    localparam logic [2:0] ALU_OR     = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_XOR    = 3'd3;
    localparam logic [2:0] ALU_PLUS   = 3'd4;
    localparam logic [2:0] ALU_MINUS  = 3'd5;
    localparam logic [2:0] ALU_SHR    = 3'd6;
    localparam logic [2:0] ALU_SHL    = 3'd7;

    localparam int         WAIT_LAST_I = (MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0;
    localparam logic [1:0] WAIT_LAST   = WAIT_LAST_I[1:0];

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_HI, S_WAIT_HI, S_FETCH_LO, S_WAIT_LO, S_LATCH, S_VALID
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        wait_cnt;
    logic [7:0]        hi_byte;
    logic [15:0]       op_w;
    logic [4:0]        d_sub;
    logic [2:0]        d_alu;
    logic              d_sw;
    logic              d_ill;

    assign out_valid = (state == S_VALID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // S_IDLE keeps mem_rd low while reset is held; fetching starts on the first edge after release.
    always_comb begin
        state_n  = state;
        mem_rd   = 1'b0;
        mem_addr = '0;
        case (state)
            S_IDLE:     state_n = S_FETCH_HI;
            S_FETCH_HI: begin
                mem_rd   = 1'b1;
                mem_addr = pc;
                state_n  = (MEM_LATENCY > 1) ? S_WAIT_HI : S_FETCH_LO;
            end
            S_WAIT_HI:  if (wait_cnt == WAIT_LAST) state_n = S_FETCH_LO;
            S_FETCH_LO: begin
                mem_rd   = 1'b1;
                mem_addr = pc + ADDR_W'(1);
                state_n  = (MEM_LATENCY > 1) ? S_WAIT_LO : S_LATCH;
            end
            S_WAIT_LO:  if (wait_cnt == WAIT_LAST) state_n = S_LATCH;
            S_LATCH:    state_n = S_VALID;
            S_VALID:    if (out_ready) state_n = S_FETCH_HI;
            default:    state_n = S_IDLE;
        endcase
        if (pc_load) state_n = S_FETCH_HI;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT_HI || state == S_WAIT_LO) begin
            wait_cnt <= wait_cnt + 2'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_RESET;
        end else if (pc_load) begin
            pc <= pc_load_addr;
        end else if (out_valid && out_ready) begin
            pc <= out_pc + (pc_skip ? ADDR_W'(4) : ADDR_W'(2));
        end
    end

    assign op_w = {hi_byte, mem_rdata};

    always_comb begin
        d_sub = 5'd0;
        d_alu = ALU_ASSIGN;
        d_sw  = 1'b0;
        d_ill = 1'b0;
        case (op_w[15:12])
            4'h0: begin
                if (op_w[11:0] == 12'h0E0)                 d_sub = 5'd1;
                else if (op_w[11:0] == 12'h0EE)            d_sub = 5'd2;
                else if (SCHIP && op_w[11:4] == 8'h0C)     d_sub = 5'd14;
                else if (SCHIP && op_w[11:0] == 12'h0FB)   d_sub = 5'd15;
                else if (SCHIP && op_w[11:0] == 12'h0FC)   d_sub = 5'd16;
                else if (SCHIP && op_w[11:0] == 12'h0FD)   d_sub = 5'd17;
                else if (SCHIP && op_w[11:0] == 12'h0FE)   d_sub = 5'd18;
                else if (SCHIP && op_w[11:0] == 12'h0FF)   d_sub = 5'd19;
                else                                       d_ill = 1'b1;
            end
            4'h5, 4'h9: d_ill = (op_w[3:0] != 4'h0);
            4'h8: begin
                case (op_w[3:0])
                    4'h0:    d_alu = ALU_ASSIGN;
                    4'h1:    d_alu = ALU_OR;
                    4'h2:    d_alu = ALU_AND;
                    4'h3:    d_alu = ALU_XOR;
                    4'h4:    d_alu = ALU_PLUS;
                    4'h5:    d_alu = ALU_MINUS;
                    4'h6:    d_alu = ALU_SHR;
                    4'h7: begin
                        d_alu = ALU_MINUS;
                        d_sw  = 1'b1;
                    end
                    4'hE:    d_alu = ALU_SHL;
                    default: d_ill = 1'b1;
                endcase
            end
            4'hE: begin
                case (op_w[7:0])
                    8'h9E:   d_sub = 5'd3;
                    8'hA1:   d_sub = 5'd4;
                    default: d_ill = 1'b1;
                endcase
            end
            4'hF: begin
                case (op_w[7:0])
                    8'h07:   d_sub = 5'd5;
                    8'h0A:   d_sub = 5'd6;
                    8'h15:   d_sub = 5'd7;
                    8'h18:   d_sub = 5'd8;
                    8'h1E:   d_sub = 5'd9;
                    8'h29:   d_sub = 5'd10;
                    8'h33:   d_sub = 5'd11;
                    8'h55:   d_sub = 5'd12;
                    8'h65:   d_sub = 5'd13;
                    8'h30:   if (SCHIP) d_sub = 5'd20; else d_ill = 1'b1;
                    8'h75:   if (SCHIP) d_sub = 5'd21; else d_ill = 1'b1;
                    8'h85:   if (SCHIP) d_sub = 5'd22; else d_ill = 1'b1;
                    default: d_ill = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    // The hi byte is sampled in FETCH_LO, exactly MEM_LATENCY cycles after its read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_byte      <= '0;
            opcode       <= '0;
            out_pc       <= '0;
            op_sub       <= '0;
            alu_op       <= '0;
            alu_switchxy <= 1'b0;
            illegal      <= 1'b0;
        end else if (!pc_load) begin
            if (state == S_FETCH_LO) hi_byte <= mem_rdata;
            if (state == S_LATCH) begin
                opcode       <= op_w;
                out_pc       <= pc;
                op_sub       <= d_sub;
                alu_op       <= d_alu;
                alu_switchxy <= d_sw;
                illegal      <= d_ill;
            end
        end
    end

    assign op_main = opcode[15:12];
    assign x       = opcode[11:8];
    assign y       = opcode[7:4];
    assign n       = opcode[3:0];
    assign nn      = opcode[7:0];
    assign nnn     = opcode[11:0];

endmodule

// File: tb/tb_chip8_fetch_decode.sv
// tb/tb_chip8_fetch_decode.sv - directed bench for chip8_fetch_decode (base, SUPER-CHIP and latency-3 instances)
module tb_chip8_fetch_decode;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:4095];

    // Instances A (base) and B (SCHIP) share all inputs; C runs with MEM_LATENCY=3.
    logic        rst_n, pc_load, pc_skip, out_ready;
    logic [11:0] pc_load_addr;
    logic [7:0]  rdata_a;
    logic        rst_n_c, out_ready_c;
    logic [7:0]  pipe_c [0:2];

    logic        mem_rd_a, mem_rd_b, mem_rd_c;
    logic [11:0] mem_addr_a, mem_addr_b, mem_addr_c;
    logic        valid_a, valid_b, valid_c;
    logic [11:0] out_pc_a, out_pc_b, out_pc_c;
    logic [15:0] opcode_a, opcode_b, opcode_c;
    logic [3:0]  op_main_a, x_a, y_a, n_a, op_main_b, x_b, y_b, n_b, op_main_c, x_c, y_c, n_c;
    logic [7:0]  nn_a, nn_b, nn_c;
    logic [11:0] nnn_a, nnn_b, nnn_c;
    logic [4:0]  op_sub_a, op_sub_b, op_sub_c;
    logic [2:0]  alu_op_a, alu_op_b, alu_op_c;
    logic        sw_a, sw_b, sw_c, ill_a, ill_b, ill_c;

    always @(posedge clk) begin
        rdata_a   <= mem[mem_addr_a];
        pipe_c[0] <= mem_rd_c ? mem[mem_addr_c] : 8'h00;
        pipe_c[1] <= pipe_c[0];
        pipe_c[2] <= pipe_c[1];
    end

    chip8_fetch_decode #(.MEM_LATENCY(1), .SCHIP(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .mem_rdata(rdata_a),
        .pc_load(pc_load), .pc_load_addr(pc_load_addr), .pc_skip(pc_skip),
        .out_valid(valid_a), .out_ready(out_ready), .out_pc(out_pc_a), .opcode(opcode_a),
        .op_main(op_main_a), .x(x_a), .y(y_a), .n(n_a), .nn(nn_a), .nnn(nnn_a),
        .op_sub(op_sub_a), .alu_op(alu_op_a), .alu_switchxy(sw_a), .illegal(ill_a));

    chip8_fetch_decode #(.MEM_LATENCY(1), .SCHIP(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_rdata(rdata_a),
        .pc_load(pc_load), .pc_load_addr(pc_load_addr), .pc_skip(pc_skip),
        .out_valid(valid_b), .out_ready(out_ready), .out_pc(out_pc_b), .opcode(opcode_b),
        .op_main(op_main_b), .x(x_b), .y(y_b), .n(n_b), .nn(nn_b), .nnn(nnn_b),
        .op_sub(op_sub_b), .alu_op(alu_op_b), .alu_switchxy(sw_b), .illegal(ill_b));

    chip8_fetch_decode #(.MEM_LATENCY(3), .SCHIP(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n_c), .mem_rd(mem_rd_c), .mem_addr(mem_addr_c), .mem_rdata(pipe_c[2]),
        .pc_load(1'b0), .pc_load_addr(12'h000), .pc_skip(1'b0),
        .out_valid(valid_c), .out_ready(out_ready_c), .out_pc(out_pc_c), .opcode(opcode_c),
        .op_main(op_main_c), .x(x_c), .y(y_c), .n(n_c), .nn(nn_c), .nnn(nnn_c),
        .op_sub(op_sub_c), .alu_op(alu_op_c), .alu_switchxy(sw_c), .illegal(ill_c));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Handshake the presented instruction, check the next fetch address, wait for the new one.
    task automatic handshake_to(input logic skip, input logic [11:0] exp_pc);
        int k;
        out_ready = 1'b1;
        pc_skip   = skip;
        @(negedge clk);
        out_ready = 1'b0;
        pc_skip   = 1'b0;
        chk("fetch_rd", {15'd0, mem_rd_a}, 16'd1);
        chk("fetch_addr", {4'd0, mem_addr_a}, {4'd0, exp_pc});
        k = 0;
        while (!valid_a && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("valid_wait", {15'd0, valid_a}, 16'd1);
        chk("out_pc", {4'd0, out_pc_a}, {4'd0, exp_pc});
    endtask

    localparam logic [2:0] ALU_MINUS = 3'd5;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h60;
        mem['h200] = 8'h00; mem['h201] = 8'hE0;
        mem['h204] = 8'h81; mem['h205] = 8'h25;
        mem['h206] = 8'h81; mem['h207] = 8'h2F;
        mem['h208] = 8'h00; mem['h209] = 8'hFF;
        mem['h20A] = 8'hF0; mem['h20B] = 8'h30;
        mem['h20C] = 8'h81; mem['h20D] = 8'h27;
        mem['hFFE] = 8'hA1; mem['hFFF] = 8'h23;
        mem['h000] = 8'h6A; mem['h001] = 8'h55;
        for (int i = 0; i < 3; i++) pipe_c[i] = 8'h00;

        rst_n = 1'b0; rst_n_c = 1'b0;
        pc_load = 1'b0; pc_load_addr = 12'h000; pc_skip = 1'b0;
        out_ready = 1'b0; out_ready_c = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {15'd0, valid_a}, 16'd0);
        chk("rst_mem_rd", {15'd0, mem_rd_a}, 16'd0);
        chk("rst_mem_addr", {4'd0, mem_addr_a}, 16'h0000);
        chk("rst_opcode", opcode_a, 16'h0000);
        chk("rst_out_pc", {4'd0, out_pc_a}, 16'h0000);
        chk("rst_b_mem_rd", {15'd0, mem_rd_b}, 16'd0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("t0_rd", {15'd0, mem_rd_a}, 16'd1);
        chk("t0_addr", {4'd0, mem_addr_a}, 16'h0200);
        @(negedge clk);
        chk("t1_rd", {15'd0, mem_rd_a}, 16'd1);
        chk("t1_addr", {4'd0, mem_addr_a}, 16'h0201);
        @(negedge clk);
        chk("t2_valid", {15'd0, valid_a}, 16'd0);
        @(negedge clk);
        chk("t3_valid", {15'd0, valid_a}, 16'd1);
        chk("cls_opcode", opcode_a, 16'h00E0);
        chk("cls_sub", {11'd0, op_sub_a}, 16'd1);
        chk("cls_pc", {4'd0, out_pc_a}, 16'h0200);
        chk("cls_ill", {15'd0, ill_a}, 16'd0);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("hold_valid", {15'd0, valid_a}, 16'd1);
            chk("hold_rd", {15'd0, mem_rd_a}, 16'd0);
            chk("hold_opcode", opcode_a, 16'h00E0);
            chk("hold_pc", {4'd0, out_pc_a}, 16'h0200);
        end

        handshake_to(1'b1, 12'h204);
        chk("8125_alu", {13'd0, alu_op_a}, {13'd0, ALU_MINUS});
        chk("8125_sw", {15'd0, sw_a}, 16'd0);

        handshake_to(1'b0, 12'h206);
        chk("812F_ill", {15'd0, ill_a}, 16'd1);
        chk("812F_alu", {13'd0, alu_op_a}, 16'd0);

        handshake_to(1'b0, 12'h208);
        chk("00FF_a_ill", {15'd0, ill_a}, 16'd1);
        chk("00FF_a_sub", {11'd0, op_sub_a}, 16'd0);
        chk("00FF_b_ill", {15'd0, ill_b}, 16'd0);
        chk("00FF_b_sub", {11'd0, op_sub_b}, 16'd19);

        handshake_to(1'b0, 12'h20A);
        chk("F030_a_ill", {15'd0, ill_a}, 16'd1);
        chk("F030_a_sub", {11'd0, op_sub_a}, 16'd0);
        chk("F030_b_ill", {15'd0, ill_b}, 16'd0);
        chk("F030_b_sub", {11'd0, op_sub_b}, 16'd20);

        handshake_to(1'b0, 12'h20C);
        chk("8127_x", {12'd0, x_a}, 16'd1);
        chk("8127_y", {12'd0, y_a}, 16'd2);
        chk("8127_alu", {13'd0, alu_op_a}, {13'd0, ALU_MINUS});
        chk("8127_sw", {15'd0, sw_a}, 16'd1);
        chk("8127_nnn", {4'd0, nnn_a}, 16'h0127);

        // Redirect while the lo byte of 0x20E is in flight.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("20E_addr", {4'd0, mem_addr_a}, 16'h020E);
        @(negedge clk);
        chk("20F_addr", {4'd0, mem_addr_a}, 16'h020F);
        pc_load = 1'b1; pc_load_addr = 12'hFFE;
        @(negedge clk);
        pc_load = 1'b0;
        chk("load_valid", {15'd0, valid_a}, 16'd0);
        chk("load_rd", {15'd0, mem_rd_a}, 16'd1);
        chk("load_addr_hi", {4'd0, mem_addr_a}, 16'h0FFE);
        @(negedge clk);
        chk("load_addr_lo", {4'd0, mem_addr_a}, 16'h0FFF);
        @(negedge clk);
        chk("load_latch_valid", {15'd0, valid_a}, 16'd0);
        @(negedge clk);
        chk("load_valid_up", {15'd0, valid_a}, 16'd1);
        chk("load_out_pc", {4'd0, out_pc_a}, 16'h0FFE);
        chk("load_opcode", opcode_a, 16'hA123);
        chk("load_nnn", {4'd0, nnn_a}, 16'h0123);
        chk("load_op_main", {12'd0, op_main_a}, 16'h000A);

        handshake_to(1'b0, 12'h000);
        chk("wrap_opcode", opcode_a, 16'h6A55);
        chk("wrap_nn", {8'd0, nn_a}, 16'h0055);

        // pc_load coincident with a skipping handshake: the redirect wins.
        out_ready = 1'b1; pc_skip = 1'b1; pc_load = 1'b1; pc_load_addr = 12'h200;
        @(negedge clk);
        out_ready = 1'b0; pc_skip = 1'b0; pc_load = 1'b0;
        chk("coinc_rd", {15'd0, mem_rd_a}, 16'd1);
        chk("coinc_addr", {4'd0, mem_addr_a}, 16'h0200);

        // Latency-3 instance: read slots at T and T+3, valid at T+7.
        rst_n_c = 1'b1;
        @(negedge clk);
        chk("c_t0_rd", {15'd0, mem_rd_c}, 16'd1);
        chk("c_t0_addr", {4'd0, mem_addr_c}, 16'h0200);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("c_rd_slot", {15'd0, mem_rd_c}, (k == 3) ? 16'd1 : 16'd0);
            chk("c_valid_slot", {15'd0, valid_c}, (k == 7) ? 16'd1 : 16'd0);
            if (k == 3) chk("c_t3_addr", {4'd0, mem_addr_c}, 16'h0201);
        end
        chk("c_opcode", opcode_c, 16'h00E0);
        chk("c_sub", {11'd0, op_sub_c}, 16'd1);
        out_ready_c = 1'b1;
        @(negedge clk);
        out_ready_c = 1'b0;
        chk("c_next_addr", {4'd0, mem_addr_c}, 16'h0202);
        @(negedge clk);
        rst_n_c = 1'b0;
        #1;
        chk("c_arst_rd", {15'd0, mem_rd_c}, 16'd0);
        chk("c_arst_valid", {15'd0, valid_c}, 16'd0);
        chk("c_arst_opcode", opcode_c, 16'h0000);
        chk("c_arst_pc", {4'd0, out_pc_c}, 16'h0000);
        chk("c_arst_addr", {4'd0, mem_addr_c}, 16'h0000);
        @(negedge clk);
        rst_n_c = 1'b1;
        @(negedge clk);
        chk("c_restart_rd", {15'd0, mem_rd_c}, 16'd1);
        chk("c_restart_addr", {4'd0, mem_addr_c}, 16'h0200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
